// File: rtl/serial_word_transmitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_word_transmitter : valid/ready word in, one bit per enabled cycle out
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module serial_word_transmitter #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       hold,
  output logic                       ser_d,
  output logic                       ser_en,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH):0]     bit_cnt
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tx_bit;
  logic [WIDTH-1:0]  shreg_next;

  // The transmit end of the register is fixed by bit order; refill with zeros.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign tx_bit     = shreg_q[WIDTH-1];
      assign shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign tx_bit     = shreg_q[0];
      assign shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    ser_en   = 1'b0;
    ser_d    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        ser_d  = tx_bit;
        ser_en = ~hold;
        if (!hold) begin
          shreg_d = shreg_next;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs stay quiet for every cycle rst is asserted, even mid-word.
    if (rst) begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      ser_en   = 1'b0;
      ser_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_transmitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_word_transmitter : directed bench with per-cycle transaction model
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_serial_word_transmitter;

  localparam int W  = 32;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_data  [2];
  logic          in_valid [2];
  logic          hold     [2];
  logic          in_ready [2];
  logic          ser_d    [2];
  logic          ser_en   [2];
  logic          busy     [2];
  logic          done     [2];
  logic [CW-1:0] bit_cnt  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_word_transmitter #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .hold(hold[0]), .ser_d(ser_d[0]), .ser_en(ser_en[0]),
    .busy(busy[0]), .done(done[0]), .bit_cnt(bit_cnt[0])
  );

  serial_word_transmitter #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .hold(hold[1]), .ser_d(ser_d[1]), .ser_en(ser_en[1]),
    .busy(busy[1]), .done(done[1]), .bit_cnt(bit_cnt[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Downstream serial-in register fed by each transmitter
  logic [W-1:0] q [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) q[k] <= '0;
      else if (ser_en[k]) q[k] <= {q[k][W-2:0], ser_d[k]};
    end
  end

  // Transaction model: phase 0 = waiting, 1 = sending bit m_sent, 2 = finished
  int           m_ph   [2];
  int           m_sent [2];
  logic [W-1:0] m_word [2];
  int ncyc = 0;
  int acc_n [2], acc_cyc [2], prev_acc_cyc [2], done_n [2], done_cyc [2], rdy_cyc [2], pulses [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_sent[k] = 0; m_word[k] = '0;
      acc_n[k] = 0; acc_cyc[k] = 0; prev_acc_cyc[k] = 0; done_n[k] = 0;
      done_cyc[k] = -1; rdy_cyc[k] = -1; pulses[k] = 0;
    end
  end

  always @(negedge clk) begin
    logic e_rdy, e_busy, e_done, e_en, e_d;
    int   e_cnt;
    ncyc++;
    for (int k = 0; k < 2; k++) begin
      e_rdy = 0; e_busy = 0; e_done = 0; e_en = 0; e_d = 0; e_cnt = 0;
      if (!rst) begin
        case (m_ph[k])
          0: e_rdy = 1;
          1: begin
            e_busy = 1;
            e_en   = ~hold[k];
            e_d    = (k == 0) ? m_word[k][W-1-m_sent[k]] : m_word[k][m_sent[k]];
            e_cnt  = m_sent[k];
          end
          default: begin
            e_done = 1;
            e_cnt  = W;
          end
        endcase
      end
      chk($sformatf("in_ready[%0d]@%0d", k, ncyc), in_ready[k], e_rdy);
      chk($sformatf("busy[%0d]@%0d", k, ncyc), busy[k], e_busy);
      chk($sformatf("done[%0d]@%0d", k, ncyc), done[k], e_done);
      chk($sformatf("ser_en[%0d]@%0d", k, ncyc), ser_en[k], e_en);
      chk($sformatf("ser_d[%0d]@%0d", k, ncyc), ser_d[k], e_d);
      if (!rst) chk($sformatf("bit_cnt[%0d]@%0d", k, ncyc), bit_cnt[k], e_cnt);

      if (in_valid[k] && in_ready[k]) begin
        prev_acc_cyc[k] = acc_cyc[k];
        acc_cyc[k] = ncyc;
        acc_n[k]++;
        pulses[k] = 0;
        rdy_cyc[k] = -1;
      end
      if (ser_en[k]) pulses[k]++;
      if (done[k]) begin
        done_n[k]++;
        done_cyc[k] = ncyc;
      end
      if (in_ready[k] && rdy_cyc[k] < 0 && done_cyc[k] > acc_cyc[k]) rdy_cyc[k] = ncyc;

      if (rst) begin
        m_ph[k] = 0; m_sent[k] = 0;
      end else begin
        case (m_ph[k])
          0: if (in_valid[k]) begin
            m_word[k] = in_data[k]; m_sent[k] = 0; m_ph[k] = 1;
          end
          1: if (!hold[k]) begin
            m_sent[k]++;
            if (m_sent[k] == W) m_ph[k] = 2;
          end
          default: begin
            m_ph[k] = 0; m_sent[k] = 0;
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [W-1:0] d);
    int n = 0;
    while (!in_ready[k] && n < 100) begin tick(); n++; end
    in_data[k] = d;
    in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int target, input string nm);
    int n = 0;
    while (done_n[k] < target && n < 200) begin tick(); n++; end
    if (done_n[k] < target) begin
      checks++; errors++;
      $display("FAIL %s: timeout, done count %0d expected %0d", nm, done_n[k], target);
    end
  endtask

  task automatic wait_acc(input int k, input int target, input string nm);
    int n = 0;
    while (acc_n[k] < target && n < 200) begin tick(); n++; end
    if (acc_n[k] < target) begin
      checks++; errors++;
      $display("FAIL %s: timeout, accept count %0d expected %0d", nm, acc_n[k], target);
    end
  endtask

  initial begin
    int dn, an;
    for (int k = 0; k < 2; k++) begin
      in_data[k] = '0; in_valid[k] = 1'b0; hold[k] = 1'b0;
    end
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, an;
    repeat (3) tick();
    chk("reset_in_ready", in_ready[0], 1'b0);
    chk("reset_bit_cnt", bit_cnt[0], 0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", in_ready[0], 1'b1);

    // Plain word, no stalls
    send(0, 32'hA5A5_0F0F);
    wait_done(0, 1, "t1_done");
    chk("t1_q", q[0], 32'hA5A5_0F0F);
    chk("t1_pulses", pulses[0], 32);
    chk("t1_done_latency", done_cyc[0] - acc_cyc[0], W + 1);
    repeat (2) tick();
    chk("t1_ready_latency", rdy_cyc[0] - acc_cyc[0], W + 2);

    // Three stall cycles after bit 5 and one on the final bit
    send(0, 32'hA5A5_0F0F);
    for (int c = 1; c <= 36; c++) begin
      hold[0] = ((c >= 7) && (c <= 9)) || (c == 35);
      tick();
    end
    hold[0] = 1'b0;
    wait_done(0, 2, "t2_done");
    chk("t2_q", q[0], 32'hA5A5_0F0F);
    chk("t2_pulses", pulses[0], 32);
    chk("t2_done_latency", done_cyc[0] - acc_cyc[0], W + 5);
    repeat (2) tick();

    // in_valid held high across two words
    an = acc_n[0];
    in_data[0] = 32'h0000_0001;
    in_valid[0] = 1'b1;
    wait_acc(0, an + 1, "t3_acc1");
    in_data[0] = 32'hFFFF_FFFF;
    wait_done(0, 3, "t3_done1");
    chk("t3_q1", q[0], 32'h0000_0001);
    wait_acc(0, an + 2, "t3_acc2");
    in_valid[0] = 1'b0;
    chk("t3_accept_spacing", acc_cyc[0] - prev_acc_cyc[0], W + 2);
    wait_done(0, 4, "t3_done2");
    chk("t3_q2", q[0], 32'hFFFF_FFFF);
    repeat (2) tick();

    // Reset in the middle of a word
    send(0, 32'hDEAD_BEEF);
    repeat (10) tick();
    chk("t4_cnt_before_rst", bit_cnt[0], 10);
    dn = done_n[0];
    rst = 1'b1;
    #1;
    chk("t4_en_in_rst", ser_en[0], 1'b0);
    chk("t4_busy_in_rst", busy[0], 1'b0);
    chk("t4_ready_in_rst", in_ready[0], 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("t4_ready_after_rst", in_ready[0], 1'b1);
    chk("t4_no_done", done_n[0], dn);
    send(0, 32'h1234_5678);
    wait_done(0, dn + 1, "t4_done");
    chk("t4_q", q[0], 32'h1234_5678);
    chk("t4_pulses", pulses[0], 32);
    repeat (2) tick();

    // LSB-first instance
    send(1, 32'h0000_0003);
    wait_done(1, 1, "t5_done");
    chk("t5_q", q[1], 32'hC000_0000);
    chk("t5_pulses", pulses[1], 32);
    repeat (2) tick();

    // in_valid pulses during SHIFT and DONE must be ignored
    an = acc_n[0];
    dn = done_n[0];
    send(0, 32'h0F0F_0F0F);
    repeat (4) tick();
    in_data[0] = 32'hFFFF_FFFF;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (27) tick();
    chk("t6_in_done_state", done[0], 1'b1);
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();
    chk("t6_accepts", acc_n[0] - an, 1);
    chk("t6_dones", done_n[0] - dn, 1);
    chk("t6_ready_latency", rdy_cyc[0] - acc_cyc[0], W + 2);
    chk("t6_q", q[0], 32'h0F0F_0F0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_word_transmitter.md
Name: serial_word_transmitter

Overview:
Parallel-to-serial front end that drives the 32-bit serial-in shift register stage. It accepts one word over a valid/ready handshake and emits it one bit per enabled cycle. For each bit it drives the downstream data input (ser_d) and shift enable (ser_en). When MSB_FIRST=1, the downstream register's Q holds exactly the accepted word after WIDTH enabled shifts. It also reports busy/done status to the controlling datapath.

Parameters:
WIDTH, 32, word length in bits; must be >= 2.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first. With 0, downstream Q ends bit-reversed.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_data  input  WIDTH  word to transmit.
in_valid  input  1  in_data valid.
in_ready  output  1  block can accept a word.
hold  input  1  stall request from the downstream side; suppresses shifting while high.
ser_d  output  1  serial data bit, connects to the downstream D_in.
ser_en  output  1  shift enable, connects to the downstream en.
busy  output  1  a word is being transmitted.
done  output  1  one-cycle pulse after the last bit is shifted.
bit_cnt  output  $clog2(WIDTH)+1  number of bits already shifted in the current word.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE, shift reg=0, bit_cnt=0.
  - Outputs while rst is high and after reset: ser_en=0, ser_d=0, busy=0, done=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after rst deasserts.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, busy=0, ser_en=0, ser_d=0.
  - On in_valid & in_ready: latch in_data into the internal shift reg, clear bit_cnt, go to SHIFT.
  - Without a handshake, stay in IDLE.
- SHIFT:
  - busy=1, in_ready=0.
  - ser_d = shift reg bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0), taken from the register output, so it is glitch-free.
  - ser_en = ~hold, combinational.
  - When ser_en=1: shift reg moves one position toward the transmit end, zero-filling; bit_cnt increments.
  - When ser_en=1 and bit_cnt==WIDTH-1: go to DONE.
  - When hold=1: shift reg, bit_cnt and state are frozen; ser_d is unchanged.
- DONE:
  - done=1, busy=0, in_ready=0, ser_en=0, ser_d=0.
  - bit_cnt reads WIDTH.
  - Next cycle: go to IDLE and clear bit_cnt.
- Latency with no hold, handshake at edge t:
  - First bit presented (ser_en=1) in cycle t+1.
  - Last bit in cycle t+WIDTH.
  - done in cycle t+WIDTH+1.
  - in_ready=1 again in cycle t+WIDTH+2.
- Each hold cycle during SHIFT extends every later event by one cycle.
- Boundary conditions:
  - hold is ignored in IDLE and DONE.
  - in_valid outside IDLE is not accepted. in_data need not stay stable after acceptance.
  - hold on the final bit delays the DONE transition until the bit is actually shifted.
  - Exactly WIDTH ser_en pulses occur per accepted word, never more.
- rst mid-SHIFT: next cycle is IDLE with ser_en=0 and no done pulse. The partial word is discarded; the downstream register is reset by its own reset.
- bit_cnt is wide enough to hold WIDTH without wrap.

Test Plan:
- MSB_FIRST=1, in_data=0xA5A5_0F0F, hold=0 -> ser_d sequence 1,0,1,0,0,1,0,1,... over 32 ser_en cycles; downstream Q=0xA5A5_0F0F; done one cycle after the last bit; in_ready back high 34 cycles after acceptance.
- Same word, hold=1 for 3 cycles after bit 5 and 1 cycle on bit 31 -> exactly 32 ser_en pulses, ser_d frozen during hold, done delayed by 4 cycles, Q=0xA5A5_0F0F.
- in_valid held high with 0x0000_0001 then 0xFFFF_FFFF -> second word accepted only in IDLE after DONE; Q=0x0000_0001, then Q=0xFFFF_FFFF after the second done.
- rst asserted at bit_cnt=10 -> ser_en=0, busy=0 and in_ready=0 while rst is high; no done pulse; in_ready=1 the cycle after rst drops; a new word 0x1234_5678 then transmits cleanly.
- MSB_FIRST=0, in_data=0x0000_0003 -> ser_d=1,1, then 0s; downstream Q=0xC000_0000.
- in_valid pulsed in SHIFT and DONE -> not accepted; in_ready stays 0; no state change.
